// File: rtl/mem_burst_ctrl.sv
// Burst memory controller: expands one cache block read fill or write-back into
// single-word BRAM accesses. Optional build macro: MEM_BURST_CRITICAL_WORD_FIRST_EN.
module mem_burst_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned BURST_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_req_op,
  input  logic                   mem_rw,
  output logic [DATA_WIDTH-1:0]  mem_read,
  output logic                   mem_read_valid,
  output logic [BURST_WIDTH-1:0] mem_offset,
  input  logic [DATA_WIDTH-1:0]  mem_write,
  output logic                   mem_write_req,
  output logic                   mem_last,
  output logic                   ready,
  output logic                   bram_en,
  output logic                   bram_we,
  output logic [ADDR_WIDTH-1:0]  bram_addr,
  output logic [DATA_WIDTH-1:0]  bram_din,
  input  logic [DATA_WIDTH-1:0]  bram_dout
);

  localparam int unsigned BASE_W = ADDR_WIDTH - BURST_WIDTH;
  localparam int unsigned CNT_W  = BURST_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << BURST_WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, RD, RD_DRAIN, WR} state_t;

  state_t                 state;
  logic [BASE_W-1:0]      base;
  logic [BURST_WIDTH-1:0] start;
  logic [CNT_W-1:0]       cnt;

  logic [CNT_W-1:0]       cnt_nxt;
  logic [BURST_WIDTH-1:0] rd_off;
  logic [BURST_WIDTH-1:0] rd_off_nxt;
  logic [BURST_WIDTH-1:0] start_in;
  logic [BASE_W-1:0]      req_base;

  // Read data and write data pass straight between the cache and the BRAM.
  assign mem_read = bram_dout;
  assign bram_din = mem_write;

  assign cnt_nxt    = cnt + CNT_W'(1);
  assign rd_off     = start + cnt[BURST_WIDTH-1:0];
  assign rd_off_nxt = start + cnt_nxt[BURST_WIDTH-1:0];
  assign req_base   = mem_addr[ADDR_WIDTH-1:BURST_WIDTH];

`ifdef MEM_BURST_CRITICAL_WORD_FIRST_EN
  assign start_in = mem_addr[BURST_WIDTH-1:0];
`else
  logic unused_low_addr;
  assign start_in        = '0;
  assign unused_low_addr = ^mem_addr[BURST_WIDTH-1:0];
`endif

  // Outputs are registered from the next-state decision so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      base           <= '0;
      start          <= '0;
      cnt            <= '0;
      mem_read_valid <= 1'b0;
      mem_offset     <= '0;
      mem_write_req  <= 1'b0;
      mem_last       <= 1'b0;
      ready          <= 1'b1;
      bram_en        <= 1'b0;
      bram_we        <= 1'b0;
      bram_addr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          mem_read_valid <= 1'b0;
          mem_last       <= 1'b0;
          if (mem_req_op) begin
            base    <= req_base;
            cnt     <= '0;
            ready   <= 1'b0;
            bram_en <= 1'b1;
            if (mem_rw) begin
              state         <= WR;
              start         <= '0;
              bram_we       <= 1'b1;
              mem_write_req <= 1'b1;
              bram_addr     <= {req_base, {BURST_WIDTH{1'b0}}};
              mem_offset    <= '0;
              mem_last      <= (LAST_CNT == '0);
            end else begin
              state     <= RD;
              start     <= start_in;
              bram_addr <= {req_base, start_in};
            end
          end
        end
        RD: begin
          // Data for the beat issued now returns next cycle, so tag it one cycle late.
          mem_read_valid <= 1'b1;
          mem_offset     <= rd_off;
          mem_last       <= (cnt == LAST_CNT);
          cnt            <= cnt_nxt;
          if (cnt == LAST_CNT) begin
            state   <= RD_DRAIN;
            bram_en <= 1'b0;
          end else begin
            bram_addr <= {base, rd_off_nxt};
          end
        end
        RD_DRAIN: begin
          state          <= IDLE;
          mem_read_valid <= 1'b0;
          mem_last       <= 1'b0;
          mem_offset     <= '0;
          cnt            <= '0;
          ready          <= 1'b1;
        end
        WR: begin
          if (cnt == LAST_CNT) begin
            state         <= IDLE;
            bram_en       <= 1'b0;
            bram_we       <= 1'b0;
            mem_write_req <= 1'b0;
            mem_last      <= 1'b0;
            mem_offset    <= '0;
            cnt           <= '0;
            ready         <= 1'b1;
          end else begin
            cnt        <= cnt_nxt;
            bram_addr  <= {base, cnt_nxt[BURST_WIDTH-1:0]};
            mem_offset <= cnt_nxt[BURST_WIDTH-1:0];
            mem_last   <= (cnt_nxt == LAST_CNT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed self-checking bench for mem_burst_ctrl with a behavioural BRAM.
module tb_mem_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic        mem_req_op;
  logic        mem_rw;
  logic [31:0] mem_read;
  logic        mem_read_valid;
  logic [4:0]  mem_offset;
  logic [31:0] mem_write;
  logic        mem_write_req;
  logic        mem_last;
  logic        ready;
  logic        bram_en;
  logic        bram_we;
  logic [15:0] bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;

  logic [31:0] bram [0:65535];
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [31:0] pre_data;
  logic [31:0] wr_base;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_write = wr_base + 32'(mem_offset);

  // Synchronous single-port BRAM with a bench preload port.
  always @(posedge clk) begin
    if (pre_we) begin
      bram[pre_addr] <= pre_data;
    end else if (bram_en) begin
      if (bram_we) bram[bram_addr] <= bram_din;
      bram_dout <= bram[bram_addr];
    end
  end

  mem_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_req_op(mem_req_op),
    .mem_rw(mem_rw), .mem_read(mem_read), .mem_read_valid(mem_read_valid),
    .mem_offset(mem_offset), .mem_write(mem_write), .mem_write_req(mem_write_req),
    .mem_last(mem_last), .ready(ready), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Issue a read burst from a negedge and check every cycle until ready returns.
  task automatic run_read(input logic [15:0] addr, input logic [31:0] dbase, input bit pulses);
    logic [4:0]  st;
    logic [4:0]  off;
`ifdef MEM_BURST_CRITICAL_WORD_FIRST_EN
    st = addr[4:0];
`else
    st = 5'd0;
`endif
    mem_addr   = addr;
    mem_rw     = 1'b0;
    mem_req_op = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      chk("rd_valid", 32'(mem_read_valid), 32'(c >= 2 && c <= 33));
      chk("rd_ready", 32'(ready), 32'(c == 34));
      chk("rd_en", 32'(bram_en), 32'(c >= 1 && c <= 32));
      if (bram_en) begin
        chk("rd_we", 32'(bram_we), 32'd0);
        chk("rd_addr_base", 32'(bram_addr[15:5]), 32'(addr[15:5]));
      end
      if (c >= 2 && c <= 33) begin
        off = st + 5'(c - 2);
        chk("rd_data", mem_read, dbase + 32'(off));
        chk("rd_offset", 32'(mem_offset), 32'(off));
        chk("rd_last", 32'(mem_last), 32'(c == 33));
      end else begin
        chk("rd_last_idle", 32'(mem_last), 32'd0);
      end
      mem_req_op = pulses && (c == 6 || c == 21 || c >= 33);
    end
  endtask

  // Issue a write burst; optionally assert reset mid-cycle during beat abort-1.
  task automatic run_write(input logic [15:0] addr, input logic [31:0] wb, input int abort);
    wr_base    = wb;
    mem_addr   = addr;
    mem_rw     = 1'b1;
    mem_req_op = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      mem_req_op = 1'b0;
      chk("wr_we", 32'(bram_we), 32'(c <= 32));
      chk("wr_req", 32'(mem_write_req), 32'(c <= 32));
      chk("wr_ready", 32'(ready), 32'(c == 33));
      if (c <= 32) begin
        chk("wr_offset", 32'(mem_offset), 32'(c - 1));
        chk("wr_last", 32'(mem_last), 32'(c == 32));
        chk("wr_addr", 32'(bram_addr), 32'(addr) + 32'(c - 1));
      end
      if (c == abort) begin
        #1 rst_n = 1'b0;
        #1;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rst_n      = 1'b0;
    mem_addr   = '0;
    mem_req_op = 1'b0;
    mem_rw     = 1'b0;
    pre_we     = 1'b0;
    pre_addr   = '0;
    pre_data   = '0;
    wr_base    = '0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_en", 32'(bram_en), 32'd0);
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_last", 32'(mem_last), 32'd0);
    chk("rst_wreq", 32'(mem_write_req), 32'd0);

    for (int i = 0; i < 32; i++) begin
      preload(16'h1220 + 16'(i), 32'hA000 + 32'(i));
      preload(16'hFFE0 + 16'(i), 32'hB000 + 32'(i));
      preload(16'h0000 + 16'(i), 32'hDEAD0000 + 32'(i));
      preload(16'h0040 + 16'(i), 32'h77770000 + 32'(i));
      preload(16'h0100 + 16'(i), 32'h11110000 + 32'(i));
    end
    preload(16'h0060, 32'h77777777);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);

    run_read(16'h1234, 32'hA000, 1'b0);

    run_write(16'h0040, 32'h5500, 0);
    for (int i = 0; i < 32; i++) chk("wr_mem", bram[16'h0040 + 16'(i)], 32'h5500 + 32'(i));
    chk("wr_mem_after", bram[16'h0060], 32'h77777777);

    run_read(16'h1234, 32'hA000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    mem_req_op = 1'b0;
    chk("held_ready", 32'(ready), 32'd0);
    chk("held_en", 32'(bram_en), 32'd1);
`ifdef MEM_BURST_CRITICAL_WORD_FIRST_EN
    chk("held_addr", 32'(bram_addr), 32'h1234);
`else
    chk("held_addr", 32'(bram_addr), 32'h1220);
`endif
    nv = 0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (mem_read_valid) nv++;
      if (ready) break;
    end
    chk("held_beats", 32'(nv), 32'd32);
    chk("held_done", 32'(ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("held_single", 32'(bram_en), 32'd0);

    run_write(16'h0100, 32'h6600, 11);
    chk("arst_we", 32'(bram_we), 32'd0);
    chk("arst_en", 32'(bram_en), 32'd0);
    chk("arst_wreq", 32'(mem_write_req), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_release", 32'(ready), 32'd1);
    for (int i = 0; i < 10; i++) chk("arst_written", bram[16'h0100 + 16'(i)], 32'h6600 + 32'(i));
    for (int i = 11; i < 32; i++) chk("arst_untouched", bram[16'h0100 + 16'(i)], 32'h11110000 + 32'(i));
    run_read(16'h1234, 32'hA000, 1'b0);

    run_read(16'hFFE0, 32'hB000, 1'b0);
    chk("top_nowrap", bram[16'h0000], 32'hDEAD0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
